// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, one bit per cycle, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              bit_s, bit_c;
  logic [WIDTH-1:0]  shift_in;
`ifdef SERIAL_ADDER_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  assign bit_s = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // The A register doubles as the sum shift register: sum bits enter at the MSB as A bits leave.
  if (WIDTH > 1) begin : g_wide
    assign shift_in = {bit_s, a_q[WIDTH-1:1]};
  end else begin : g_one
    assign shift_in = bit_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub | cin;
        end
      end
      StRun: begin
        a_d     = shift_in;
        b_d     = b_q >> 1;
        carry_d = bit_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          state_d = StDone;
          cnt_d   = '0;
          sum_d   = shift_in;
          cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ bit_c;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=1 instances checked against an arithmetic model.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       s8, sub8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       s1, sub1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf1;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0] last_sum8;
  logic       last_cout8;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(s8),
    .sub  (sub8),
    .a    (a8),
    .b    (b8),
    .cin  (cin8),
    .busy (busy8),
    .done (done8),
    .sum  (sum8),
    .cout (cout8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk  (clk),
    .rst  (rst),
    .start(s1),
    .sub  (sub1),
    .a    (a1),
    .b    (b1),
    .cin  (cin1),
    .busy (busy1),
    .done (done1),
    .sum  (sum1),
    .cout (cout1)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular and signed arithmetic on whole operands.
  function automatic void model8(input logic [7:0] ma, input logic [7:0] mb, input logic msub,
                                 input logic mcin, output logic [7:0] es, output logic ec,
                                 output logic eo);
    int sa, sb, r;
    logic [8:0] full;
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (!msub) begin
      full = {1'b0, ma} + {1'b0, mb} + {8'd0, mcin};
      es   = full[7:0];
      ec   = full[8];
      r    = sa + sb + int'(mcin);
    end else begin
      es = ma - mb;
      ec = (ma >= mb);
      r  = sa - sb;
    end
    eo = (r > 127) || (r < -128);
  endfunction

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tsub,
                      input logic tcin);
    logic [7:0] es;
    logic ec, eo;
    int n;
    model8(ta, tb, tsub, tcin, es, ec, eo);
    s8 = 1'b1; a8 = ta; b8 = tb; sub8 = tsub; cin8 = tcin;
    tick();
    // Scramble inputs after capture; the running operation must not see them.
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom); cin8 = 1'($urandom);
    chk("busy_after_start", busy8, 1'b1);
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      chk("hold_sum_in_run", sum8, last_sum8);
      tick();
      n++;
    end
    chk("latency_edges", n, 8);
    chk("sum", sum8, es);
    chk("cout", cout8, ec);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", ovf8, eo);
`endif
    chk("busy_in_done", busy8, 1'b1);
    tick();
    chk("done_one_cycle", done8, 1'b0);
    chk("idle_after_done", busy8, 1'b0);
    chk("sum_held", sum8, es);
    last_sum8  = es;
    last_cout8 = ec;
  endtask

  initial begin
    logic [7:0] es;
    logic ec, eo;
    logic [1:0] exp1 [8];
    int ndone, done_at;

    exp1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    s1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset with start asserted: reset wins.
    rst = 1'b1; s8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; cin8 = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_sum", sum8, 8'h00);
    chk("rst_cout", cout8, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", ovf8, 1'b0);
`endif
    chk("rst_busy_w1", busy1, 1'b0);
    rst = 1'b0; s8 = 1'b0;
    tick();
    chk("idle_no_start", busy8, 1'b0);
    last_sum8 = 8'h00; last_cout8 = 1'b0;

    run8(8'hFF, 8'h01, 1'b0, 1'b0);
    run8(8'h05, 8'h07, 1'b1, 1'b1);
    run8(8'h07, 8'h05, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h80, 8'h01, 1'b1, 1'b0);

    // Second start three cycles into RUN is ignored.
    model8(8'h3C, 8'h5A, 1'b0, 1'b1, es, ec, eo);
    s8 = 1'b1; a8 = 8'h3C; b8 = 8'h5A; sub8 = 1'b0; cin8 = 1'b1;
    tick();
    s8 = 1'b0;
    tick();
    tick();
    s8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; cin8 = 1'b0;
    tick();
    s8 = 1'b0;
    ndone = 0; done_at = 0;
    for (int k = 4; k <= 20; k++) begin
      if (done8 === 1'b1) begin
        ndone++;
        done_at = k - 1;
        chk("ignored_start_sum", sum8, es);
        chk("ignored_start_cout", cout8, ec);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ignored_start_ovf", ovf8, eo);
`endif
      end
      tick();
    end
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_done_edge", done_at, 8);
    chk("ignored_start_idle", busy8, 1'b0);
    last_sum8 = es; last_cout8 = ec;

    // Reset four cycles into RUN aborts the operation.
    s8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b0; cin8 = 1'b0;
    tick();
    s8 = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_sum", sum8, 8'h00);
    chk("abort_cout", cout8, 1'b0);
    last_sum8 = 8'h00; last_cout8 = 1'b0;
    run8(8'h64, 8'h9D, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    // WIDTH=1: a registered full adder.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      s1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      tick();
      s1 = 1'b0; a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
      chk("w1_busy", busy1, 1'b1);
      chk("w1_not_done_early", done1, 1'b0);
      tick();
      chk("w1_done", done1, 1'b1);
      chk("w1_result", {cout1, sum1}, exp1[i]);
      tick();
      chk("w1_idle", busy1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
